sm83_idu_ctl: RTL and testbench
===============================

SM83_IDU_CTL -- requirements
Module: sm83_idu_ctl

Interface
REQ-001 SHALL have parameter EARLY_DONE, default 0: 1 permits completion after the low-byte step when no carry/borrow occurs.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-003 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port req, input, 3: request per requester; bit 0 PC, bit 1 SP, bit 2 HL.
REQ-005 SHALL have port op, input, 3x2: operation per requester; 00 pass, 01 inc, 10 dec, 11 treated as pass.
REQ-006 SHALL have port opnd, input, 3x16: operand per requester.
REQ-007 SHALL have port gnt, output, 3: one-hot grant, combinational, high only in the acceptance cycle.
REQ-008 SHALL have port busy, output, 1: high while in state LO or HI.
REQ-009 SHALL have port done, output, 1: registered single-cycle completion pulse.
REQ-010 SHALL have port done_id, output, 2: index of the requester whose result is presented.
REQ-011 SHALL have port result, output, 16: registered result, held until the next done.
REQ-012 SHALL have port wrap, output, 1: registered; high with done when inc of 16'hFFFF or dec of 16'h0000 occurred.

Function
REQ-013 SHALL implement states IDLE, LO and HI.
REQ-014 In IDLE with any req bit high, SHALL raise exactly one gnt bit, latch that requester's op and opnd at the clock edge, and go to LO.
REQ-015 SHALL arbitrate round-robin: search starts at the index after the last granted requester and wraps 2->0.
REQ-016 SHALL never raise gnt outside IDLE; requesters hold req until they see gnt.
REQ-017 In LO, SHALL compute the low byte (+1, -1 or pass) and latch byte result and carry/borrow.
REQ-018 In LO, SHALL go to HI, except when EARLY_DONE=1 and no carry/borrow occurred; in that case it SHALL copy the high byte unchanged and complete.
REQ-019 In HI, SHALL apply the latched carry/borrow to the high byte and complete.
REQ-020 On completion, SHALL return to IDLE and in the next cycle assert done for exactly one cycle with result, done_id and wrap valid.
REQ-021 Latency: gnt in cycle T gives done in cycle T+3 (T+2 with an early exit). IDLE in the done cycle SHALL allow a new gnt in that same cycle.
REQ-022 Arithmetic SHALL be modulo 2^16; pass SHALL give result = opnd and wrap = 0.
REQ-023 Changes to req, op or opnd after gnt SHALL NOT affect the operation in flight.
REQ-024 A requester that drops req before being granted SHALL NOT be granted.

Reset
REQ-025 While reset is high at a clock edge: state becomes IDLE; done, wrap, busy become 0; result becomes 16'h0000; done_id becomes 0; round-robin last-granted pointer becomes 2 (HL), so PC has first priority.
REQ-026 Reset during LO or HI SHALL abort the operation with no done pulse.
REQ-027 gnt SHALL be 0 in any cycle where reset is high.

Structure
REQ-028 Shared package sm83_idu_pkg SHALL hold the op enum, the state enum (IDLE/LO/HI) and the requester index constants (PC=0, SP=1, HL=2).
REQ-029 SHALL instantiate one sub-module sm83_idu_byte (8-bit inc/dec/pass with carry-in, carry-out), reused in LO and HI.
REQ-030 SHALL keep the round-robin pointer and the operand/op latches in this module, not in the package.

Verification
REQ-031 Reset release; req=001, op PC=inc, opnd=16'h12FE -> gnt=001 in cycle 0; done in cycle 3; result=16'h12FF; wrap=0; done_id=0.
REQ-032 req=111 held continuously, all inc, opnds 0100/0200/0300 -> grants in order PC, SP, HL, PC, with one grant every 3 cycles.
REQ-033 SP dec, opnd 16'h0000 -> result 16'hFFFF, wrap=1; HL inc, opnd 16'hFFFF -> result 16'h0000, wrap=1.
REQ-034 EARLY_DONE=1: inc 16'h3410 -> done at T+2, result 16'h3411; inc 16'h34FF -> done at T+3, result 16'h3500.
REQ-035 Reset asserted in HI -> no done pulse; next request after release is granted PC-first with result 0 until then.
REQ-036 opnd changed to 16'hAAAA one cycle after gnt (original 16'h0005, dec) -> result 16'h0004.

Source files
------------

// File: rtl/sm83_idu_pkg.sv
// sm83_idu_pkg: shared op/state encodings and requester indices for the SM83 IDU
package sm83_idu_pkg;
    typedef enum logic [1:0] {OP_PASS = 2'b00, OP_INC = 2'b01, OP_DEC = 2'b10, OP_PASS_ALT = 2'b11} op_e;
    typedef enum logic [1:0] {IDLE, LO, HI} state_e;
    localparam logic [1:0] PC = 2'd0;
    localparam logic [1:0] SP = 2'd1;
    localparam logic [1:0] HL = 2'd2;
endpackage

// File: rtl/sm83_idu_ctl_if.sv
// sm83_idu_ctl_if: requester-side bus of the SM83 increment/decrement unit
interface sm83_idu_ctl_if;
    logic [2:0]       req;
    logic [2:0][1:0]  op;
    logic [2:0][15:0] opnd;
    logic [2:0]       gnt;
    logic             busy;
    logic             done;
    logic [1:0]       done_id;
    logic [15:0]      result;
    logic             wrap;
    modport master (output req, op, opnd, input gnt, busy, done, done_id, result, wrap);
    modport slave (input req, op, opnd, output gnt, busy, done, done_id, result, wrap);
endinterface

// File: rtl/sm83_idu_byte.sv
// sm83_idu_byte: 8-bit increment/decrement/pass slice with carry-in and carry-out
module sm83_idu_byte
    import sm83_idu_pkg::*;
(
    input  op_e        op,
    input  logic [7:0] a,
    input  logic       ci,
    output logic [7:0] y,
    output logic       co
);
    logic [8:0] s;
    always_comb begin
        s = (op == OP_INC) ? {1'b0, a} + {8'd0, ci} : (op == OP_DEC) ? {1'b0, a} - {8'd0, ci} : {1'b0, a};
        y = s[7:0];
        co = s[8];
    end
endmodule

// File: rtl/sm83_idu_ctl.sv
// sm83_idu_ctl: round-robin arbitrated 16-bit inc/dec unit working one byte per cycle
module sm83_idu_ctl
    import sm83_idu_pkg::*;
#(
    parameter bit EARLY_DONE = 1'b0
) (
    input logic           clk,
    input logic           reset,
    sm83_idu_ctl_if.slave bus
);
    state_e      state, state_n;
    logic [1:0]  last, c0, c1, gid, lat_id, done_id_q;
    op_e         lat_op;
    logic [15:0] lat_opnd, result_q;
    logic [7:0]  lo, a, y;
    logic        ci, co, cy, fin, done_q, wrap_q;
    // search starts one past the last grant and wraps HL -> PC
    always_comb begin
        c0 = (last == HL) ? PC : last + 2'd1;
        c1 = (c0 == HL) ? PC : c0 + 2'd1;
        gid = bus.req[c0] ? c0 : bus.req[c1] ? c1 : last;
        bus.gnt = (state == IDLE && !reset && |bus.req) ? 3'b001 << gid : 3'b000;
    end
    assign a = (state == HI) ? lat_opnd[15:8] : lat_opnd[7:0];
    assign ci = (state == HI) ? cy : 1'b1;
    sm83_idu_byte u_byte (
        .op(lat_op),
        .a (a),
        .ci(ci),
        .y (y),
        .co(co)
    );
    assign fin = (state == HI) || (state == LO && EARLY_DONE && !co);
    always_comb begin
        state_n = state;
        state_n = (state == IDLE) ? (|bus.gnt ? LO : IDLE) : (state == LO) ? (fin ? IDLE : HI) : IDLE;
    end
    always_ff @(posedge clk) state <= reset ? IDLE : state_n;
    always_ff @(posedge clk) begin
        if (reset) begin
            last <= HL;
            done_q <= 1'b0;
            wrap_q <= 1'b0;
            result_q <= 16'h0000;
            done_id_q <= PC;
        end else begin
            done_q <= fin;
            if (|bus.gnt) begin
                last <= gid;
                lat_id <= gid;
                lat_op <= op_e'(bus.op[gid]);
                lat_opnd <= bus.opnd[gid];
            end
            if (state == LO) begin
                lo <= y;
                cy <= co;
            end
            if (fin) begin
                result_q <= (state == HI) ? {y, lo} : {lat_opnd[15:8], y};
                wrap_q <= (state == HI) && co;
                done_id_q <= lat_id;
            end
        end
    end
    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.done_id = done_id_q;
    assign bus.result = result_q;
    assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_sm83_idu_ctl.sv
// tb_sm83_idu_ctl: scoreboard bench for sm83_idu_ctl in normal and early-done builds
module tb_sm83_idu_ctl;
    import sm83_idu_pkg::*;
    typedef struct {
        logic [1:0]  id;
        logic [15:0] res;
        logic        wrap;
        int          cyc;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    logic [2:0]       req_d [2];
    logic [2:0][1:0]  op_d [2];
    logic [2:0][15:0] opnd_d [2];
    logic [2:0]       gnt_w [2];
    logic             busy_w [2];
    logic             done_w [2];
    logic             wrap_w [2];
    logic [1:0]       id_w [2];
    logic [15:0]      res_w [2];
    exp_t q0[$];
    exp_t q1[$];
    int glog_id[$];
    int glog_cyc[$];

    sm83_idu_ctl_if b0 ();
    sm83_idu_ctl_if b1 ();
    sm83_idu_ctl #(.EARLY_DONE(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
    sm83_idu_ctl #(.EARLY_DONE(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(b1));

    assign b0.req = req_d[0];
    assign b0.op = op_d[0];
    assign b0.opnd = opnd_d[0];
    assign b1.req = req_d[1];
    assign b1.op = op_d[1];
    assign b1.opnd = opnd_d[1];
    assign gnt_w[0] = b0.gnt;
    assign gnt_w[1] = b1.gnt;
    assign busy_w[0] = b0.busy;
    assign busy_w[1] = b1.busy;
    assign done_w[0] = b0.done;
    assign done_w[1] = b1.done;
    assign wrap_w[0] = b0.wrap;
    assign wrap_w[1] = b1.wrap;
    assign id_w[0] = b0.done_id;
    assign id_w[1] = b1.done_id;
    assign res_w[0] = b0.result;
    assign res_w[1] = b1.result;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input int s, input int id, input logic [1:0] o, input logic [15:0] v, input int t);
        exp_t e;
        logic lo_carry;
        e.id = 2'(id);
        e.res = (o == 2'b01) ? v + 16'd1 : (o == 2'b10) ? v - 16'd1 : v;
        e.wrap = (o == 2'b01 && v == 16'hFFFF) || (o == 2'b10 && v == 16'h0000);
        lo_carry = (o == 2'b01 && v[7:0] == 8'hFF) || (o == 2'b10 && v[7:0] == 8'h00);
        e.cyc = t + ((s == 1 && !lo_carry) ? 2 : 3);
        return e;
    endfunction

    // grants push expectations, done pulses pop and compare
    always @(negedge clk) begin
        exp_t e;
        int gid;
        for (int s = 0; s < 2; s++) begin
            if (done_w[s] === 1'b1) begin
                vectors++;
                if ((s == 0 ? q0.size() : q1.size()) == 0) begin
                    miscompares++;
                    $display("FAIL spurious_done dut%0d: got done id=%0d result=%h, required no done", s, id_w[s], res_w[s]);
                end else begin
                    if (s == 0) e = q0.pop_front();
                    else e = q1.pop_front();
                    if (res_w[s] !== e.res || wrap_w[s] !== e.wrap || id_w[s] !== e.id || cyc != e.cyc) begin
                        miscompares++;
                        $display("FAIL done dut%0d: got id=%0d result=%h wrap=%b cycle=%0d, required id=%0d result=%h wrap=%b cycle=%0d",
                                 s, id_w[s], res_w[s], wrap_w[s], cyc, e.id, e.res, e.wrap, e.cyc);
                    end
                end
            end
            if (gnt_w[s] !== 3'b000) begin
                gid = gnt_w[s][1] ? 1 : gnt_w[s][2] ? 2 : 0;
                vectors++;
                if (!$onehot(gnt_w[s]) || (gnt_w[s] & ~req_d[s]) != 3'b000 || busy_w[s] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL gnt_legal dut%0d: got gnt=%b busy=%b req=%b, required one-hot subset of req while idle",
                             s, gnt_w[s], busy_w[s], req_d[s]);
                end
                if (s == 0) begin
                    q0.push_back(model(s, gid, op_d[s][gid], opnd_d[s][gid], cyc));
                    glog_id.push_back(gid);
                    glog_cyc.push_back(cyc);
                end else q1.push_back(model(s, gid, op_d[s][gid], opnd_d[s][gid], cyc));
            end
        end
    end

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (q0.size() != 0 || q1.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: got %0d/%0d results outstanding, required 0", q0.size(), q1.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int s, input int id, input logic [1:0] o, input logic [15:0] v);
        logic seen = 1'b0;
        op_d[s][id] = o;
        opnd_d[s][id] = v;
        req_d[s][id] = 1'b1;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            seen = gnt_w[s][id];
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL grant_timeout dut%0d id=%0d: got no gnt, required gnt", s, id);
        end
        @(posedge clk);
        #1;
        req_d[s][id] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int s = 0; s < 2; s++) begin
            req_d[s] = 3'b111;
            op_d[s] = '0;
            opnd_d[s] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            vectors++;
            if (gnt_w[s] !== 3'b000 || busy_w[s] !== 1'b0 || done_w[s] !== 1'b0 || wrap_w[s] !== 1'b0 ||
                res_w[s] !== 16'h0000 || id_w[s] !== 2'd0) begin
                miscompares++;
                $display("FAIL reset_state dut%0d: got gnt=%b busy=%b done=%b wrap=%b result=%h id=%0d, required all zero",
                         s, gnt_w[s], busy_w[s], done_w[s], wrap_w[s], res_w[s], id_w[s]);
            end
        end
        @(posedge clk);
        #1;
        req_d[0] = 3'b000;
        req_d[1] = 3'b000;
        reset = 1'b0;
    endtask

    task automatic test_round_robin();
        int order[4] = '{0, 1, 2, 0};
        glog_id.delete();
        glog_cyc.delete();
        op_d[0] = {2'b01, 2'b01, 2'b01};
        opnd_d[0] = {16'h0300, 16'h0200, 16'h0100};
        req_d[0] = 3'b111;
        for (int n = 0; n < 30 && glog_id.size() < 4; n++) @(negedge clk);
        @(posedge clk);
        #1;
        req_d[0] = 3'b000;
        vectors++;
        if (glog_id.size() < 4) begin
            miscompares++;
            $display("FAIL rr_count: got %0d grants, required 4", glog_id.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (glog_id[k] != order[k] || (k > 0 && glog_cyc[k] - glog_cyc[k-1] != 3)) begin
                    miscompares++;
                    $display("FAIL rr_order[%0d]: got id=%0d spacing=%0d, required id=%0d spacing=3",
                             k, glog_id[k], k > 0 ? glog_cyc[k] - glog_cyc[k-1] : 3, order[k]);
                end
            end
        end
        drain();
    endtask

    task automatic test_basic();
        issue(0, 0, 2'b01, 16'h12FE);
        drain();
    endtask

    task automatic test_wrap();
        issue(0, 1, 2'b10, 16'h0000);
        drain();
        issue(0, 2, 2'b01, 16'hFFFF);
        drain();
        issue(0, 2, 2'b11, 16'hBEEF);
        drain();
        issue(0, 0, 2'b01, 16'h3410);
        drain();
    endtask

    task automatic test_early();
        issue(1, 0, 2'b01, 16'h3410);
        drain();
        issue(1, 0, 2'b01, 16'h34FF);
        drain();
        issue(1, 1, 2'b10, 16'h1200);
        drain();
        issue(1, 2, 2'b10, 16'h1201);
        drain();
        issue(1, 1, 2'b00, 16'hCAFE);
        drain();
        issue(1, 2, 2'b01, 16'hFFFF);
        drain();
    endtask

    task automatic test_reset_abort();
        issue(0, 0, 2'b01, 16'h1111);
        @(posedge clk);
        #1;
        reset = 1'b1;
        q0.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            vectors++;
            if (res_w[0] !== 16'h0000 || busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_state: got result=%h busy=%b done=%b, required 0000/0/0", res_w[0], busy_w[0], done_w[0]);
            end
        end
        @(posedge clk);
        #1;
        glog_id.delete();
        glog_cyc.delete();
        op_d[0] = '0;
        opnd_d[0] = {16'h0003, 16'h0002, 16'h0001};
        req_d[0] = 3'b111;
        @(negedge clk);
        @(posedge clk);
        #1;
        req_d[0] = 3'b000;
        vectors++;
        if (glog_id.size() != 1 || glog_id[0] != 0) begin
            miscompares++;
            $display("FAIL abort_pc_first: got %0d grants first id=%0d, required 1 grant id=0", glog_id.size(), glog_id.size() ? glog_id[0] : -1);
        end
        drain();
    endtask

    task automatic test_inflight();
        issue(0, 0, 2'b10, 16'h0005);
        opnd_d[0][0] = 16'hAAAA;
        op_d[0][0] = 2'b01;
        drain();
    endtask

    task automatic test_back_to_back();
        logic [2:0] g;
        glog_id.delete();
        glog_cyc.delete();
        op_d[0] = {2'b10, 2'b01, 2'b01};
        opnd_d[0] = {16'h0100, 16'h0FFF, 16'h00FF};
        req_d[0] = 3'b101;
        for (int n = 0; n < 20 && (req_d[0][0] | req_d[0][2]); n++) begin
            @(negedge clk);
            g = gnt_w[0];
            @(posedge clk);
            #1;
            req_d[0] = req_d[0] & ~g;
            if (n == 1) req_d[0][1] = 1'b1;
            if (n == 2) req_d[0][1] = 1'b0;
        end
        req_d[0] = 3'b000;
        drain();
        vectors++;
        if (glog_id.size() != 2 || glog_id[0] != 2 || glog_id[1] != 0 || glog_cyc[1] - glog_cyc[0] != 3) begin
            miscompares++;
            $display("FAIL back_to_back: got %0d grants ids=%0d,%0d, required 2 grants HL then PC 3 cycles apart",
                     glog_id.size(), glog_id.size() > 0 ? glog_id[0] : -1, glog_id.size() > 1 ? glog_id[1] : -1);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_basic();
        test_wrap();
        test_early();
        test_reset_abort();
        test_inflight();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish within budget");
        $fatal(1, "watchdog expired");
    end
endmodule
